// File: rtl/reg_bank_arbiter_if.sv
// Bus between the requesting datapath stages and the register-bank arbiter.
// The bus carries the packed write requests, the registered grant and the asynchronous read port.
//   master : requester side. It drives req, wr_addr, wr_data and rd_addr,
//            and it observes gnt, gnt_valid, gnt_id and rd_data.
//   slave  : arbiter side, with the directions reversed.
interface reg_bank_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int ID_W   = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] wr_addr;
    logic [NUM_REQ*WIDTH-1:0]  wr_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      gnt_valid;
    logic [ID_W-1:0]           gnt_id;
    logic [ADDR_W-1:0]         rd_addr;
    logic [WIDTH-1:0]          rd_data;

    modport master (
        output req, wr_addr, wr_data, rd_addr,
        input  gnt, gnt_valid, gnt_id, rd_data
    );

    modport slave (
        input  req, wr_addr, wr_data, rd_addr,
        output gnt, gnt_valid, gnt_id, rd_data
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter in front of a shared flip-flop register bank.
// Each clock it picks one eligible requester, searching from the round-robin pointer.
// It writes that requester's word into the bank and raises a one-hot grant for one cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : reg_bank_arbiter_if.slave (requests, grant, read port)
module reg_bank_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4
) (
    input logic               clk,
    input logic               rst,
    reg_bank_arbiter_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int ID_W   = $clog2(NUM_REQ);

    logic [WIDTH-1:0]   bank [DEPTH];
    logic [NUM_REQ-1:0] gnt_q;
    logic [ID_W-1:0]    gnt_id_q;
    logic [ID_W-1:0]    ptr;

    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [ADDR_W-1:0]  win_addr;
    logic [WIDTH-1:0]   win_data;

    // A requester granted this cycle is masked.
    // This lets it drop req in response to gnt without causing a second write.
    assign eligible = bus.req & ~gnt_q;

    // Search from ptr upwards.
    // NUM_REQ is a power of two, so the ID_W-bit add wraps modulo NUM_REQ by itself.
    always_comb begin
        logic [ID_W-1:0] cand;
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr + ID_W'(k);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign win_addr = bus.wr_addr[win_id*ADDR_W +: ADDR_W];
    assign win_data = bus.wr_data[win_id*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr      <= '0;
        end else if (win_found) begin
            bank[win_addr] <= win_data;
            gnt_q          <= NUM_REQ'(1) << win_id;
            gnt_id_q       <= win_id;
            ptr            <= win_id + ID_W'(1);
        end else begin
            gnt_q <= '0;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = |gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    // During a write cycle the read port still shows the old value.
    // The new word appears only after the edge.
    assign bus.rd_data   = bank[bus.rd_addr];
endmodule

// File: tb/tb_reg_bank_arbiter.sv
module tb_reg_bank_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_bank_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) bus();

    reg_bank_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference state: plain integers, no encoding tied to the design
    int m_bank [D];
    int m_ptr = 0;
    int m_id  = 0;
    int m_gnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input int a, input int d);
        bus.wr_addr[i*AW +: AW] = AW'(a);
        bus.wr_data[i*W +: W]   = W'(d);
    endtask

    // Rules: eligible = req minus last grant, first eligible from ptr wins.
    task automatic model_edge();
        int w;
        if (rst) begin
            for (int i = 0; i < D; i++) m_bank[i] = 0;
            m_gnt = 0; m_ptr = 0; m_id = 0;
        end else begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (w < 0 && bus.req[idx] && ((m_gnt >> idx) & 1) == 0) w = idx;
            end
            if (w >= 0) begin
                m_bank[int'(bus.wr_addr[w*AW +: AW])] = int'(bus.wr_data[w*W +: W]);
                m_gnt = 1 << w;
                m_id  = w;
                m_ptr = (w + 1) % N;
            end else begin
                m_gnt = 0;
            end
        end
    endtask

    task automatic cycle();
        #1;
        chk("rd_pre_edge", 32'(bus.rd_data), 32'(m_bank[int'(bus.rd_addr)]));
        model_edge();
        @(posedge clk);
        #1;
        chk("gnt", 32'(bus.gnt), 32'(m_gnt));
        chk("gnt_valid", 32'(bus.gnt_valid), 32'(m_gnt != 0));
        chk("gnt_id", 32'(bus.gnt_id), 32'(m_id));
        chk("rd_post_edge", 32'(bus.rd_data), 32'(m_bank[int'(bus.rd_addr)]));
    endtask

    initial begin
        int exp_seq [5];
        exp_seq = '{1, 2, 4, 8, 1};
        for (int i = 0; i < D; i++) m_bank[i] = 0;
        bus.req     = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;

        // reset with all requesting, own address, data 10+i
        rst = 1'b1;
        bus.req = 4'b1111;
        for (int i = 0; i < N; i++) set_req(i, i, 8'h10 + i);
        repeat (2) begin
            cycle();
            chk("rst_gnt", 32'(bus.gnt), 0);
            chk("rst_valid", 32'(bus.gnt_valid), 0);
        end
        for (int a = 0; a < D; a++) begin
            bus.rd_addr = AW'(a);
            #1 chk("rst_rd", 32'(bus.rd_data), 0);
        end
        rst = 1'b0;

        // full contention
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_seq", 32'(bus.gnt), 32'(exp_seq[k]));
        end
        bus.req = '0;
        for (int a = 0; a < D; a++) begin
            bus.rd_addr = AW'(a);
            #1 chk("rr_bank", 32'(bus.rd_data), 32'(8'h10 + a));
        end

        // single requester, masked every other cycle
        rst = 1'b1; cycle(); rst = 1'b0;
        bus.req = 4'b0100;
        set_req(2, 2, 8'hA5);
        bus.rd_addr = 2'd2;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("single_gnt", 32'(bus.gnt), (k % 2 == 0) ? 32'h4 : 32'h0);
            chk("single_rd", 32'(bus.rd_data), 32'hA5);
        end

        // wrap and skip: ptr is 3 now
        bus.req = 4'b0011;
        set_req(0, 0, 8'h01);
        set_req(1, 1, 8'h02);
        cycle(); chk("wrap_first", 32'(bus.gnt_id), 0);
        cycle(); chk("wrap_second", 32'(bus.gnt_id), 1);

        // same-address collision, ptr is 2
        bus.req = 4'b1010;
        set_req(1, 0, 8'h11);
        set_req(3, 0, 8'h33);
        bus.rd_addr = 2'd0;
        cycle(); chk("coll_first", 32'(bus.gnt_id), 3);
        bus.req = 4'b0010;
        cycle(); chk("coll_second", 32'(bus.gnt_id), 1);
        bus.req = 4'b0000;
        cycle(); chk("coll_bank0", 32'(bus.rd_data), 32'h11);

        // reset mid-operation discards the winner
        bus.req = 4'b0100;
        set_req(2, 1, 8'hFF);
        bus.rd_addr = 2'd1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_bank1", 32'(bus.rd_data), 0);
        chk("midrst_gnt", 32'(bus.gnt), 0);
        bus.req = 4'b1111;
        cycle(); chk("midrst_ptr0", 32'(bus.gnt), 1);

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            bus.req = N'($urandom);
            for (int i = 0; i < N; i++) set_req(i, $urandom_range(D-1), $urandom_range(255));
            bus.rd_addr = AW'($urandom);
            rst = ($urandom_range(49) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Round-robin write arbiter for a shared bank of D flip-flop registers. Up to NUM_REQ requesters each present an address and a data word. The block grants one requester per clock and writes that requester's word into the bank. It sits between the requesting datapath stages and the flip-flop storage they share, and it also provides an asynchronous read port on the bank.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..8
- WIDTH, 8, data bits per register
- DEPTH, 4, number of registers in the bank; power of two; ADDR_W = log2(DEPTH)

Ports:
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous, active-high reset, sampled on rising edge of clk
- req  in  NUM_REQ  per-requester write request; bit i belongs to requester i
- wr_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- wr_data  in  NUM_REQ*WIDTH  packed data; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  out  NUM_REQ  registered one-hot grant; bit i high for one cycle after requester i's word was written
- gnt_valid  out  1  OR of gnt
- gnt_id  out  log2(NUM_REQ)  index of the set gnt bit; holds its last value when gnt_valid=0
- rd_addr  in  ADDR_W  read address
- rd_data  out  WIDTH  bank[rd_addr], combinational

## Operation
- Eligible set at each edge: req & ~gnt.
  - A requester granted in the current cycle is masked, so it can drop req in response to gnt without a duplicate write.
- Round-robin pointer ptr (log2(NUM_REQ) bits) marks the highest-priority requester.
  - Search order: ptr, ptr+1, ... mod NUM_REQ.
  - The first eligible requester wins.
- On a win by requester w at an edge:
  - bank[wr_addr_w] <= wr_data_w
  - gnt <= one-hot(w); gnt_id <= w
  - ptr <= (w+1) mod NUM_REQ
- No eligible requester: gnt <= 0, ptr and gnt_id unchanged, bank unchanged.
- Only the winner's address and data are used; losing requesters' wr_addr and wr_data are ignored.
- Handshake for requesters:
  - Hold req, wr_addr and wr_data stable until gnt[i] is seen high.
  - The word has already been written by the time gnt[i] is visible.
  - Keeping req high during the gnt cycle is legal. It is ignored that cycle and arbitrated again at the next edge, which is treated as a new write.
- Read port:
  - rd_data = bank[rd_addr], asynchronous.
  - A write to rd_addr shows on rd_data only after the edge; during the writing cycle rd_data shows the old value.

## Timing
- Reset (rst=1 at an edge):
  - All bank registers = 0, gnt = 0, gnt_valid = 0, gnt_id = 0, ptr = 0.
  - rd_data therefore reads 0 after reset.
  - Reset overrides any pending write in that cycle; no bank register changes other than clearing.
- Reset mid-operation: any winner on the reset edge is discarded. That requester must re-request; it sees no gnt.
- Latency:
  - req sampled at edge k, data written at edge k, gnt high in cycle k..k+1.
  - Grant latency is one cycle when the requester wins immediately.
- Throughput:
  - Aggregate: one write per cycle.
  - A single requester: at most one write every 2 cycles, because of masking.
- Fairness: with N continuously requesting requesters, each is granted exactly once in any window of N consecutive grants.
- ptr wrap-around: after a win by requester NUM_REQ-1, ptr = 0.
- Same address from several requesters in one cycle: only the winner writes; the losers' writes occur in later grants, in round-robin order.

## Test plan
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, gnt_valid=0, rd_data=0 for rd_addr 0..3; after release, first grant goes to requester 0.
- Single requester: req=4'b0100 with addr=2, data=8'hA5, held 4 cycles -> writes at edges 1 and 3 only, gnt=4'b0100 in alternating cycles, rd_data(2)=A5 after the first edge.
- Full contention: req=4'b1111 held, each requester writing its own address with data 8'h10+i -> gnt sequence 0001, 0010, 0100, 1000, 0001; bank = 10, 11, 12, 13.
- Wrap and skip: ptr=3 after a grant to 2, then req=4'b0011 -> requester 0 granted, then requester 1.
- Same-address collision: requesters 1 and 3 both write addr 0 (data 8'h11, 8'h33) with ptr=2 -> requester 3 wins first, then requester 1; final bank[0]=8'h11.
- Reset mid-operation: rst=1 on an edge where requester 2 would write 8'hFF to addr 1 -> bank[1]=0, gnt=0, ptr=0.
